// File: rtl/spi_txn_scheduler_if.sv
// Signal bundle for spi_txn_scheduler.
//   master modport : the scheduler itself (grants requesters, drives the SPI master)
//   slave modport  : the environment (requesters plus the SPI mode-0 master)
// timeout_err is present only when SPI_TIMEOUT_EN is defined.
interface spi_txn_scheduler_if #(
  parameter int NUM_REQ = 4
);
  // requester side
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_len;
  logic [NUM_REQ*8-1:0] tx_data;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_pop;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 done;
  logic                 busy;
  // SPI master side
  logic                 SCLK_PULSE;
  logic                 ENABLE;
  logic [7:0]           MOSI_data;
  logic [7:0]           MISO_data;
  logic [7:0]           master_stash_ptr;
`ifdef SPI_TIMEOUT_EN
  logic                 timeout_err;
`endif

  modport master (
    input  req, req_len, tx_data, MISO_data, master_stash_ptr,
`ifdef SPI_TIMEOUT_EN
    output timeout_err,
`endif
    output grant, tx_pop, rx_data, rx_valid, done, busy,
    output SCLK_PULSE, ENABLE, MOSI_data
  );

  modport slave (
    output req, req_len, tx_data, MISO_data, master_stash_ptr,
`ifdef SPI_TIMEOUT_EN
    input  timeout_err,
`endif
    input  grant, tx_pop, rx_data, rx_valid, done, busy,
    input  SCLK_PULSE, ENABLE, MOSI_data
  );
endinterface

// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin sharing of one SPI mode-0 master between
// NUM_REQ requesters. Generates the master's bit-rate strobe, drives its
// active-low ENABLE, streams the owner's TX bytes and returns RX bytes,
// using increments of master_stash_ptr as the byte-done indication.
// Optional feature macro: SPI_TIMEOUT_EN (abort a stalled transaction after
// TIMEOUT_PULSES bit strobes without a byte completion, sticky timeout_err).
module spi_txn_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int CLK_DIV        = 4,
  parameter int GUARD_PULSES   = 2,
  parameter int TIMEOUT_PULSES = 64
) (
  input  logic                CTRL_CLK,
  input  logic                NRST,
  spi_txn_scheduler_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GRD_W = $clog2(GUARD_PULSES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_PULSES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
`ifdef SPI_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_PULSES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_PULSES - 1);
`endif

  // Reject parameter values the datapath cannot honour
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("spi_txn_scheduler: NUM_REQ must be in 2..8");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("spi_txn_scheduler: CLK_DIV must be >= 2");
    end
    if (GUARD_PULSES < 1) begin : g_bad_guard
      $error("spi_txn_scheduler: GUARD_PULSES must be >= 1");
    end
    if (TIMEOUT_PULSES < 1) begin : g_bad_timeout
      $error("spi_txn_scheduler: TIMEOUT_PULSES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STOP
  } state_t;

  state_t             state_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [IDX_W-1:0]   last_grant_reg;
  logic [7:0]         remaining_reg;
  logic [7:0]         ptr_snap_reg;
  logic [GRD_W-1:0]   guard_cnt_reg;
  logic               tx_pop_reg;
  logic [7:0]         rx_data_reg;
  logic               rx_valid_reg;
  logic               done_reg;
  logic               busy_reg;
  logic               enable_reg;
  logic [7:0]         mosi_reg;
`ifdef SPI_TIMEOUT_EN
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic               timeout_err_reg;
`endif

  logic               sclk_pulse;
  logic               ptr_moved;
  logic               pick_hit;
  logic [IDX_W-1:0]   pick_idx;

  // Per-requester views of the packed length / data buses
  logic [7:0]         len_arr [NUM_REQ];
  logic [7:0]         tx_arr  [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign len_arr[gi]  = bus.req_len[8*gi +: 8];
      assign tx_arr[gi]   = bus.tx_data[8*gi +: 8];
      assign eligible[gi] = bus.req[gi] && (len_arr[gi] != 8'd0);
    end
  endgenerate

  // Free-running bit-rate divider; it never stops so the master keeps its cadence
  always_ff @(posedge CTRL_CLK or negedge NRST) begin
    if (!NRST) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign sclk_pulse = (div_cnt_reg == DIV_LAST);

  // Any change of the master's byte counter (including the 255->0 wrap) is one byte done
  assign ptr_moved = (bus.master_stash_ptr != ptr_snap_reg);

  // Round-robin search: scan downwards so the candidate closest after last_grant wins
  always_comb begin : rr_search
    logic [IDX_W-1:0] cand;
    pick_hit = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
      if (eligible[cand]) begin
        pick_hit = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Transaction FSM with registered outputs; strobes default low every cycle
  always_ff @(posedge CTRL_CLK or negedge NRST) begin
    if (!NRST) begin
      state_reg       <= S_IDLE;
      grant_reg       <= '0;
      owner_reg       <= '0;
      last_grant_reg  <= IDX_LAST;
      remaining_reg   <= 8'd0;
      ptr_snap_reg    <= 8'd0;
      guard_cnt_reg   <= '0;
      tx_pop_reg      <= 1'b0;
      rx_data_reg     <= 8'd0;
      rx_valid_reg    <= 1'b0;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      enable_reg      <= 1'b1;
      mosi_reg        <= 8'd0;
`ifdef SPI_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      tx_pop_reg   <= 1'b0;
      rx_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pick_hit) begin
            grant_reg     <= NUM_REQ'(1) << pick_idx;
            owner_reg     <= pick_idx;
            remaining_reg <= len_arr[pick_idx];
            busy_reg      <= 1'b1;
            state_reg     <= S_LOAD;
          end
        end
        S_LOAD: begin
          mosi_reg     <= tx_arr[owner_reg];
          tx_pop_reg   <= 1'b1;
          ptr_snap_reg <= bus.master_stash_ptr;
          enable_reg   <= 1'b0;
`ifdef SPI_TIMEOUT_EN
          tmo_cnt_reg  <= '0;
`endif
          state_reg    <= S_RUN;
        end
        S_RUN: begin
          if (ptr_moved) begin
            ptr_snap_reg  <= bus.master_stash_ptr;
            rx_data_reg   <= bus.MISO_data;
            rx_valid_reg  <= 1'b1;
            remaining_reg <= remaining_reg - 8'd1;
`ifdef SPI_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
`endif
            if (remaining_reg == 8'd1) begin
              enable_reg    <= 1'b1;
              guard_cnt_reg <= '0;
              state_reg     <= S_STOP;
            end else begin
              // next byte is in place well before the master's next load strobe
              mosi_reg   <= tx_arr[owner_reg];
              tx_pop_reg <= 1'b1;
            end
          end
`ifdef SPI_TIMEOUT_EN
          else if (sclk_pulse) begin
            if (tmo_cnt_reg == TMO_LAST) begin
              // stalled master: abort straight to IDLE, partial byte discarded
              enable_reg      <= 1'b1;
              timeout_err_reg <= 1'b1;
              done_reg        <= 1'b1;
              grant_reg       <= '0;
              last_grant_reg  <= owner_reg;
              busy_reg        <= 1'b0;
              state_reg       <= S_IDLE;
            end else begin
              tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
          end
`endif
        end
        S_STOP: begin
          if (sclk_pulse) begin
            if (guard_cnt_reg == GRD_LAST) begin
              done_reg       <= 1'b1;
              grant_reg      <= '0;
              last_grant_reg <= owner_reg;
              busy_reg       <= 1'b0;
              state_reg      <= S_IDLE;
            end else begin
              guard_cnt_reg <= guard_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant      = grant_reg;
  assign bus.tx_pop     = tx_pop_reg;
  assign bus.rx_data    = rx_data_reg;
  assign bus.rx_valid   = rx_valid_reg;
  assign bus.done       = done_reg;
  assign bus.busy       = busy_reg;
  assign bus.SCLK_PULSE = sclk_pulse;
  assign bus.ENABLE     = enable_reg;
  assign bus.MOSI_data  = mosi_reg;
`ifdef SPI_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_reg;
`endif

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Testbench for spi_txn_scheduler: directed transactions against a behavioural
// SPI master that returns the bitwise inverse of each byte it shifted out.
// Expected events are queued when stimulus is issued; a monitor checks them.
module tb_spi_txn_scheduler;

  localparam int NUM_REQ        = 4;
  localparam int CLK_DIV        = 4;
  localparam int GUARD_PULSES   = 2;
  localparam int TIMEOUT_PULSES = 64;
  localparam int BUDGET         = 3000;

  localparam logic [1:0] EV_POP  = 2'd0;
  localparam logic [1:0] EV_RX   = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;

  logic CTRL_CLK = 1'b0;
  logic NRST     = 1'b0;
  always #5 CTRL_CLK = ~CTRL_CLK;

  spi_txn_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  spi_txn_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .CLK_DIV        (CLK_DIV),
    .GUARD_PULSES   (GUARD_PULSES),
    .TIMEOUT_PULSES (TIMEOUT_PULSES)
  ) dut (
    .CTRL_CLK (CTRL_CLK),
    .NRST     (NRST),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  ev_t        exp_q [$];
  logic [7:0] tab [NUM_REQ][8];
  logic [2:0] pos [NUM_REQ];
  int         exp_pos [NUM_REQ];

  // ---------------- SPI master model ----------------
  logic [7:0] stash_base = 8'd0;
  logic [7:0] stash_cnt  = 8'd0;
  logic [2:0] bit_cnt    = 3'd0;
  logic [7:0] mosi_lat   = 8'd0;
  logic [7:0] miso_reg   = 8'd0;
  logic       stall      = 1'b0;
  logic       expect_guard = 1'b1;

  always @(posedge CTRL_CLK) begin
    if (bus.ENABLE) begin
      bit_cnt <= 3'd0;
    end else if (bus.SCLK_PULSE && !stall) begin
      if (bit_cnt == 3'd0) mosi_lat <= bus.MOSI_data;
      if (bit_cnt == 3'd7) begin
        miso_reg  <= ~mosi_lat;
        stash_cnt <= stash_cnt + 8'd1;
      end
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign bus.MISO_data        = miso_reg;
  assign bus.master_stash_ptr = stash_base + stash_cnt;

  // Requester data: each requester presents tab[i][pos[i]]
  always_comb begin
    bus.tx_data = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.tx_data[8*i +: 8] = tab[i][pos[i]];
  end

  // Requester advances its byte pointer half a cycle after tx_pop
  initial forever begin
    @(negedge CTRL_CLK);
    if (NRST && bus.tx_pop) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.grant[i]) pos[i] = pos[i] + 3'd1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_evt(input logic [1:0] kind, input logic [7:0] val, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s: got %0h want no event", name, val);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'({kind, val}), 32'({e.kind, e.val}));
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Queue the event sequence of one complete transaction of requester r
  task automatic push_txn(input int r, input int len);
    logic [NUM_REQ-1:0] g;
    logic [2:0]         idx;
    g    = '0;
    g[r] = 1'b1;
    push_ev(EV_POP, 8'(g));
    for (int k = 0; k < len; k++) begin
      idx = 3'(exp_pos[r] + k);
      push_ev(EV_RX, ~tab[r][idx]);
      if (k < len - 1) push_ev(EV_POP, 8'(g));
    end
    push_ev(EV_DONE, 8'(g));
    exp_pos[r] += len;
  endtask

  task automatic wait_dones(input int n, input string name);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < BUDGET) begin
      @(negedge CTRL_CLK);
      cyc++;
      if (bus.done) seen++;
    end
    check({name, "_dones"}, 32'(seen), 32'(n));
  endtask

  task automatic clear_requesters();
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i]     = 3'd0;
      exp_pos[i] = 0;
      for (int k = 0; k < 8; k++) tab[i][k] = 8'd0;
    end
  endtask

  task automatic do_reset();
    @(negedge CTRL_CLK);
    NRST = 1'b0;
    exp_q.delete();
    clear_requesters();
    repeat (3) @(negedge CTRL_CLK);
    NRST = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [NUM_REQ-1:0] cur_owner = '0;
  int                 hi_pulses = 0;

  initial forever begin
    @(negedge CTRL_CLK);
    if (NRST) begin
      if (bus.grant != '0) cur_owner = bus.grant;
      if (bus.rx_valid) check_evt(EV_RX, bus.rx_data, "rx");
      if (bus.tx_pop) begin
        check_evt(EV_POP, 8'(bus.grant), "pop");
        check("enable_low_on_pop", 32'(bus.ENABLE), 32'd0);
      end
      if (bus.done) begin
        check_evt(EV_DONE, 8'(cur_owner), "done");
        if (expect_guard) check("guard_pulses", 32'(hi_pulses), 32'(GUARD_PULSES));
        $display("txn done owner=%b", cur_owner);
      end
      if (!bus.ENABLE) hi_pulses = 0;
      else if (bus.SCLK_PULSE) hi_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bus.req     = '0;
    bus.req_len = '0;
    clear_requesters();

    // reset state
    NRST = 1'b0;
    repeat (3) @(negedge CTRL_CLK);
    check("rst_grant",    32'(bus.grant),      32'd0);
    check("rst_tx_pop",   32'(bus.tx_pop),     32'd0);
    check("rst_rx_data",  32'(bus.rx_data),    32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid),   32'd0);
    check("rst_done",     32'(bus.done),       32'd0);
    check("rst_busy",     32'(bus.busy),       32'd0);
    check("rst_sclk",     32'(bus.SCLK_PULSE), 32'd0);
    check("rst_enable",   32'(bus.ENABLE),     32'd1);
    check("rst_mosi",     32'(bus.MOSI_data),  32'd0);
`ifdef SPI_TIMEOUT_EN
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
`endif
    NRST = 1'b1;

    // single requester, three bytes
    tab[0][0] = 8'hA5; tab[0][1] = 8'h3C; tab[0][2] = 8'hF0;
    push_txn(0, 3);
    bus.req_len = {8'd0, 8'd0, 8'd0, 8'd3};
    bus.req     = 4'b0001;
    wait_dones(1, "single");
    bus.req = '0;
    repeat (6) @(negedge CTRL_CLK);
    check("single_idle_enable", 32'(bus.ENABLE), 32'd1);
    check("single_idle_busy",   32'(bus.busy),   32'd0);

    // round robin over four always-requesting clients
    do_reset();
    tab[0][0] = 8'h10; tab[0][1] = 8'h20;
    tab[1][0] = 8'h11; tab[2][0] = 8'h12; tab[3][0] = 8'h13;
    push_txn(0, 1); push_txn(1, 1); push_txn(2, 1); push_txn(3, 1); push_txn(0, 1);
    bus.req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.req     = 4'b1111;
    wait_dones(5, "round_robin");
    bus.req = '0;

    // zero-length requester is skipped
    do_reset();
    tab[2][0] = 8'h77;
    push_txn(2, 1);
    bus.req_len = {8'd0, 8'd1, 8'd0, 8'd0};
    bus.req     = 4'b0110;
    wait_dones(1, "skip_len0");
    bus.req = '0;

    // byte counter wraps 255 -> 0 during the transaction
    repeat (4) @(negedge CTRL_CLK);
    stash_base = 8'hFE - stash_cnt;
    tab[0][0] = 8'h01; tab[0][1] = 8'h02; tab[0][2] = 8'h03; tab[0][3] = 8'h04;
    push_txn(0, 4);
    bus.req_len = {8'd0, 8'd0, 8'd0, 8'd4};
    bus.req     = 4'b0001;
    wait_dones(1, "ptr_wrap");
    bus.req = '0;

    // reset during byte 2 of 4
    repeat (4) @(negedge CTRL_CLK);
    tab[0][4] = 8'h11; tab[0][5] = 8'h22; tab[0][6] = 8'h33; tab[0][7] = 8'h44;
    push_txn(0, 4);
    bus.req_len = {8'd0, 8'd0, 8'd0, 8'd4};
    bus.req     = 4'b0001;
    cyc = 0;
    while (!bus.rx_valid && cyc < BUDGET) begin
      @(negedge CTRL_CLK);
      cyc++;
    end
    check("midrst_first_byte_seen", 32'(bus.rx_valid), 32'd1);
    NRST    = 1'b0;
    bus.req = '0;
    #1;
    check("midrst_enable", 32'(bus.ENABLE), 32'd1);
    check("midrst_grant",  32'(bus.grant),  32'd0);
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_done",   32'(bus.done),   32'd0);
    exp_q.delete();
    clear_requesters();
    repeat (3) @(negedge CTRL_CLK);
    NRST = 1'b1;
    repeat (8) @(negedge CTRL_CLK);
    check("midrst_idle_busy", 32'(bus.busy), 32'd0);
    tab[0][0] = 8'h55; tab[2][0] = 8'h66;
    push_txn(0, 1); push_txn(2, 1);
    bus.req_len = {8'd0, 8'd1, 8'd0, 8'd1};
    bus.req     = 4'b0101;
    wait_dones(2, "after_reset");
    bus.req = '0;

`ifdef SPI_TIMEOUT_EN
    // stalled master: abort after TIMEOUT_PULSES strobes
    repeat (4) @(negedge CTRL_CLK);
    stall        = 1'b1;
    expect_guard = 1'b0;
    tab[3][0] = 8'h9A; tab[3][1] = 8'hBC;
    push_ev(EV_POP, 8'h08);
    push_ev(EV_DONE, 8'h08);
    bus.req_len = {8'd2, 8'd0, 8'd0, 8'd0};
    bus.req     = 4'b1000;
    wait_dones(1, "timeout");
    bus.req = '0;
    check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    check("timeout_enable",  32'(bus.ENABLE),      32'd1);
    check("timeout_busy",    32'(bus.busy),        32'd0);
    repeat (4) @(negedge CTRL_CLK);
    check("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
    stall        = 1'b0;
    expect_guard = 1'b1;
`endif

    repeat (10) @(negedge CTRL_CLK);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
